// File: rtl/segment_scroller.sv
// segment_scroller: scrolls a 6-character window over a short message held in
// a 16-entry buffer and drives six active-low 7-segment displays.
//
// Ports:
//   CLOCK_50        system clock
//   reset           synchronous active-high reset (clears pos, wrap, buffer, HEX)
//   tick            one-cycle step enable
//   dir             0 = scroll left (pos+1), 1 = scroll right (pos-1)
//   pause           1 = ignore tick
//   wr_en/wr_addr/wr_data  message buffer write port (5-bit character codes)
//   msg_len         active message length (0 treated as 1, >16 as 16)
//   pos             index of the character currently on HEX5
//   wrap            one-cycle pulse after a step that wrapped pos
//   HEX5..HEX0      registered active-low segments, bit0 = a .. bit6 = g
module segment_scroller #(
   parameter int MSG_DEPTH = 16
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       tick,
   input  logic       dir,
   input  logic       pause,
   input  logic       wr_en,
   input  logic [3:0] wr_addr,
   input  logic [4:0] wr_data,
   input  logic [4:0] msg_len,
   output logic [3:0] pos,
   output logic       wrap,
   output logic [6:0] HEX0,
   output logic [6:0] HEX1,
   output logic [6:0] HEX2,
   output logic [6:0] HEX3,
   output logic [6:0] HEX4,
   output logic [6:0] HEX5
);

   logic [4:0] msg_q [MSG_DEPTH];
   logic [3:0] pos_q, pos_d;
   logic       wrap_q, wrap_d;
   logic [6:0] hex_q [6];      // hex_q[k] drives HEX(5-k)
   logic [6:0] seg_d [6];
   logic [3:0] idx [6];

   logic [4:0] len_eff;
   logic [3:0] last_idx;
   logic       range_bad;
   logic       step;

   function automatic logic [6:0] seg7(input logic [4:0] code);
      case (code)
         5'h00: seg7 = 7'h40;
         5'h01: seg7 = 7'h79;
         5'h02: seg7 = 7'h24;
         5'h03: seg7 = 7'h30;
         5'h04: seg7 = 7'h19;
         5'h05: seg7 = 7'h12;
         5'h06: seg7 = 7'h02;
         5'h07: seg7 = 7'h78;
         5'h08: seg7 = 7'h00;
         5'h09: seg7 = 7'h10;
         5'h0A: seg7 = 7'h08;
         5'h0B: seg7 = 7'h03;
         5'h0C: seg7 = 7'h46;
         5'h0D: seg7 = 7'h21;
         5'h0E: seg7 = 7'h06;
         5'h0F: seg7 = 7'h0E;
         5'h11: seg7 = 7'h3F;
         default: seg7 = 7'h7F;  // 10h blank, 12h-1Fh shown as blank
      endcase
   endfunction

   always_comb begin
      if (msg_len == 5'd0)
         len_eff = 5'd1;
      else if (msg_len > 5'(MSG_DEPTH))
         len_eff = 5'(MSG_DEPTH);
      else
         len_eff = msg_len;
   end

   assign last_idx  = 4'(len_eff - 5'd1);
   // pos can be left outside the message when msg_len shrinks
   assign range_bad = ({1'b0, pos_q} >= len_eff);
   assign step      = tick & ~pause & ~range_bad;

   always_comb begin
      pos_d  = pos_q;
      wrap_d = 1'b0;
      if (range_bad) begin
         pos_d = 4'd0;               // the fix wins; any tick this edge is lost
      end else if (step) begin
         if (!dir) begin
            pos_d  = (pos_q == last_idx) ? 4'd0 : pos_q + 4'd1;
            wrap_d = (pos_q == last_idx);
         end else begin
            pos_d  = (pos_q == 4'd0) ? last_idx : pos_q - 4'd1;
            wrap_d = (pos_q == 4'd0);
         end
      end
   end

   // Window indices as a chain of modulo-L incrementers: each digit is the
   // previous one plus one, folding back to 0 past L-1, so short messages
   // repeat across the display. While pos is out of range (a single cycle
   // before the fix lands) the window is anchored at 0.
   always_comb begin
      idx[0] = range_bad ? 4'd0 : pos_q;
      for (int k = 1; k < 6; k++)
         idx[k] = (idx[k-1] == last_idx) ? 4'd0 : idx[k-1] + 4'd1;
      for (int k = 0; k < 6; k++)
         seg_d[k] = seg7(msg_q[idx[k]]);
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         pos_q  <= 4'd0;
         wrap_q <= 1'b0;
         for (int i = 0; i < MSG_DEPTH; i++)
            msg_q[i] <= 5'h10;
         for (int k = 0; k < 6; k++)
            hex_q[k] <= 7'h7F;
      end else begin
         pos_q  <= pos_d;
         wrap_q <= wrap_d;
         if (wr_en)
            msg_q[wr_addr] <= wr_data;
         for (int k = 0; k < 6; k++)
            hex_q[k] <= seg_d[k];
      end
   end

   assign pos  = pos_q;
   assign wrap = wrap_q;
   assign HEX5 = hex_q[0];
   assign HEX4 = hex_q[1];
   assign HEX3 = hex_q[2];
   assign HEX2 = hex_q[3];
   assign HEX1 = hex_q[4];
   assign HEX0 = hex_q[5];

endmodule

// File: tb/tb_segment_scroller.sv
module tb_segment_scroller;

   logic       CLOCK_50 = 1'b0;
   logic       reset, tick, dir, pause, wr_en;
   logic [3:0] wr_addr;
   logic [4:0] wr_data, msg_len;
   logic [3:0] pos;
   logic       wrap;
   logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

   int vectors = 0;
   int errors  = 0;

   logic [4:0]  mem [16];        // reference copy of the message buffer
   int          mpos;            // reference pos
   logic [41:0] exp_q [$];       // expected {HEX5..HEX0}, one entry per edge
   logic [41:0] exp_w, obs_w;

   segment_scroller #(.MSG_DEPTH(16)) dut (
      .CLOCK_50(CLOCK_50), .reset(reset), .tick(tick), .dir(dir), .pause(pause),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .msg_len(msg_len),
      .pos(pos), .wrap(wrap),
      .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [6:0] seg_ref(input logic [4:0] c);
      logic [6:0] tbl [18];
      tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E,
              7'h7F, 7'h3F};
      return (c < 5'd18) ? tbl[c] : 7'h7F;
   endfunction

   function automatic int eff_len(input logic [4:0] m);
      if (m == 0) return 1;
      if (m > 16) return 16;
      return int'(m);
   endfunction

   function automatic logic [41:0] win(input int p, input int l);
      logic [41:0] r;
      r = '0;
      for (int k = 0; k < 6; k++)
         r[41-7*k -: 7] = seg_ref(mem[(p + k) % l]);
      return r;
   endfunction

   function automatic logic [41:0] hex_obs();
      return {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
   endfunction

   task automatic cyc();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc();
      cyc();
      reset = 1'b0;
      for (int i = 0; i < 16; i++) mem[i] = 5'h10;
      mpos = 0;
   endtask

   task automatic write(input int a, input logic [4:0] d);
      wr_en = 1'b1; wr_addr = 4'(a); wr_data = d;
      mem[a] = d;
      cyc();
      wr_en = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      vectors++;
      if (pos !== 4'd0 || wrap !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: pos=%0d wrap=%0b, want pos=0 wrap=0", pos, wrap);
      end
      vectors++;
      if (hex_obs() !== {6{7'h7F}}) begin
         errors++;
         $display("FAIL reset_hex: got %h, want all 7F", hex_obs());
      end
      msg_len = 5'd8;
      tick = 1'b1;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(win(mpos, 8));
         cyc();
         mpos = (mpos + 1) % 8;
         exp_w = exp_q.pop_front();
         vectors++;
         if (hex_obs() !== exp_w || exp_w !== {6{7'h7F}}) begin
            errors++;
            $display("FAIL blank_scroll[%0d]: got %h, want %h", i, hex_obs(), exp_w);
         end
      end
      tick = 1'b0;
   endtask

   task automatic test_load_window();
      do_reset();
      msg_len = 5'd8;
      for (int i = 0; i < 8; i++) write(i, 5'(i));
      cyc();
      exp_q.push_back(win(0, 8));
      cyc();
      exp_w = exp_q.pop_front();
      vectors++;
      if (hex_obs() !== exp_w || hex_obs() !== {7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12}) begin
         errors++;
         $display("FAIL load_window: got %h, want %h", hex_obs(), exp_w);
      end
      tick = 1'b1; dir = 1'b0;
      cyc();
      tick = 1'b0;
      mpos = 1;
      vectors++;
      if (pos !== 4'd1) begin
         errors++;
         $display("FAIL first_step_pos: got %0d, want 1", pos);
      end
      exp_q.push_back(win(1, 8));
      cyc();
      exp_w = exp_q.pop_front();
      vectors++;
      if (hex_obs() !== exp_w || hex_obs() !== {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}) begin
         errors++;
         $display("FAIL step_window: got %h, want %h", hex_obs(), exp_w);
      end
   endtask

   task automatic test_wrap();
      // back to pos 0 with a right step from pos 1 (no wrap)
      dir = 1'b1; tick = 1'b1;
      cyc();
      tick = 1'b0;
      mpos = 0;
      vectors++;
      if (pos !== 4'd0 || wrap !== 1'b0) begin
         errors++;
         $display("FAIL back_to_zero: pos=%0d wrap=%0b, want 0/0", pos, wrap);
      end
      dir = 1'b0; tick = 1'b1;
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back(win(mpos, 8));
         cyc();
         mpos = (mpos + 1) % 8;
         exp_w = exp_q.pop_front();
         vectors++;
         if (pos !== 4'(mpos) || wrap !== (i == 7)) begin
            errors++;
            $display("FAIL wrap_left[%0d]: pos=%0d wrap=%0b, want pos=%0d wrap=%0b",
                     i, pos, wrap, mpos, (i == 7));
         end
         vectors++;
         if (hex_obs() !== exp_w) begin
            errors++;
            $display("FAIL wrap_left_hex[%0d]: got %h, want %h", i, hex_obs(), exp_w);
         end
      end
      tick = 1'b0;
      cyc();
      vectors++;
      if (wrap !== 1'b0) begin
         errors++;
         $display("FAIL wrap_pulse_width: wrap=%0b, want 0", wrap);
      end
      dir = 1'b1; tick = 1'b1;
      cyc();
      tick = 1'b0;
      mpos = 7;
      vectors++;
      if (pos !== 4'd7 || wrap !== 1'b1) begin
         errors++;
         $display("FAIL wrap_right: pos=%0d wrap=%0b, want 7/1", pos, wrap);
      end
      cyc();
      vectors++;
      if (wrap !== 1'b0) begin
         errors++;
         $display("FAIL wrap_right_width: wrap=%0b, want 0", wrap);
      end
   endtask

   task automatic test_pause();
      pause = 1'b1; tick = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cyc();
         vectors++;
         if (pos !== 4'(mpos) || wrap !== 1'b0) begin
            errors++;
            $display("FAIL pause[%0d]: pos=%0d wrap=%0b, want %0d/0", i, pos, wrap, mpos);
         end
      end
      pause = 1'b0; tick = 1'b0;
   endtask

   task automatic test_short_msg();
      do_reset();
      dir = 1'b0;
      for (int i = 0; i < 3; i++) write(i, 5'(i));
      msg_len = 5'd3;
      cyc();
      exp_q.push_back(win(0, 3));
      cyc();
      exp_w = exp_q.pop_front();
      vectors++;
      if (hex_obs() !== exp_w || hex_obs() !== {7'h40, 7'h79, 7'h24, 7'h40, 7'h79, 7'h24}) begin
         errors++;
         $display("FAIL len3_window: got %h, want %h", hex_obs(), exp_w);
      end
      msg_len = 5'd0;
      cyc();
      exp_q.push_back(win(0, eff_len(5'd0)));
      cyc();
      exp_w = exp_q.pop_front();
      vectors++;
      if (hex_obs() !== exp_w || hex_obs() !== {6{7'h40}}) begin
         errors++;
         $display("FAIL len0_window: got %h, want %h", hex_obs(), exp_w);
      end
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      vectors++;
      if (pos !== 4'd0 || wrap !== 1'b1) begin
         errors++;
         $display("FAIL len1_step: pos=%0d wrap=%0b, want 0/1", pos, wrap);
      end
      msg_len = 5'd20;
      cyc();
      exp_q.push_back(win(0, eff_len(5'd20)));
      cyc();
      exp_w = exp_q.pop_front();
      vectors++;
      if (hex_obs() !== exp_w) begin
         errors++;
         $display("FAIL len_clamp_window: got %h, want %h", hex_obs(), exp_w);
      end
   endtask

   task automatic test_shrink();
      do_reset();
      dir = 1'b0;
      msg_len = 5'd8;
      for (int i = 0; i < 8; i++) write(i, 5'(i));
      tick = 1'b1;
      for (int i = 0; i < 6; i++) cyc();
      mpos = 6;
      vectors++;
      if (pos !== 4'd6) begin
         errors++;
         $display("FAIL shrink_setup: pos=%0d, want 6", pos);
      end
      msg_len = 5'd4;   // tick still high on this edge
      cyc();
      tick = 1'b0;
      mpos = 0;
      vectors++;
      if (pos !== 4'd0 || wrap !== 1'b0) begin
         errors++;
         $display("FAIL shrink_fix: pos=%0d wrap=%0b, want 0/0", pos, wrap);
      end
      exp_q.push_back(win(0, 4));
      cyc();
      exp_w = exp_q.pop_front();
      vectors++;
      if (hex_obs() !== exp_w || pos !== 4'd0) begin
         errors++;
         $display("FAIL shrink_window: hex=%h pos=%0d, want hex=%h pos=0", hex_obs(), pos, exp_w);
      end
   endtask

   task automatic test_reset_mid();
      msg_len = 5'd8; dir = 1'b0; tick = 1'b1;
      for (int i = 0; i < 5; i++) cyc();
      vectors++;
      if (pos !== 4'd5) begin
         errors++;
         $display("FAIL mid_setup: pos=%0d, want 5", pos);
      end
      reset = 1'b1; wr_en = 1'b1; wr_addr = 4'd2; wr_data = 5'h05;
      cyc();
      reset = 1'b0; wr_en = 1'b0; tick = 1'b0;
      for (int i = 0; i < 16; i++) mem[i] = 5'h10;
      mpos = 0;
      vectors++;
      if (pos !== 4'd0 || wrap !== 1'b0 || hex_obs() !== {6{7'h7F}}) begin
         errors++;
         $display("FAIL reset_mid: pos=%0d wrap=%0b hex=%h, want 0/0/all 7F", pos, wrap, hex_obs());
      end
      exp_q.push_back(win(0, 8));
      cyc();
      exp_w = exp_q.pop_front();
      vectors++;
      if (hex_obs() !== exp_w || HEX3 !== 7'h7F) begin
         errors++;
         $display("FAIL reset_mid_write_dropped: got %h, want %h", hex_obs(), exp_w);
      end
   endtask

   initial begin
      reset = 1'b1; tick = 1'b0; dir = 1'b0; pause = 1'b0; wr_en = 1'b0;
      wr_addr = 4'd0; wr_data = 5'd0; msg_len = 5'd8;
      test_reset();
      test_load_window();
      test_wrap();
      test_pause();
      test_short_msg();
      test_shrink();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
